mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one external mult_1x1 instance among NUM_REQ requesters.
- mult_1x1 is a combinational signed 16x16 -> 32 multiplier: Q8.8 operands, Q16.16 product.
- This block accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier operands from registers.
- It waits a programmable settle time for the gate-level netlist, then returns the product tagged with the requester index over a single valid/ready response port.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of resp_id; must satisfy 2^ID_W >= NUM_REQ.
- CALC_CYCLES, 1: cycles operands are held on mult_a/mult_b before the product is sampled, 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*16  packed signed Q8.8 operand A; requester i occupies bits [16i+15:16i].
- req_b  in  NUM_REQ*16  packed signed Q8.8 operand B, same packing as req_a.
- mult_a  out  16  registered operand to mult_1x1 .a.
- mult_b  out  16  registered operand to mult_1x1 .b.
- mult_out  in  32  mult_1x1 .out, signed Q16.16.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  registered signed Q16.16 product.
- resp_id  out  ID_W  index of the requester that owns resp_data.

Behaviour:
- Reset, applied on any clk edge with rst_n=0 and regardless of state:
  - state=IDLE, rr_ptr=0, calc counter=0.
  - mult_a=0, mult_b=0, resp_valid=0, resp_data=0, resp_id=0, req_ready=0.
  - An in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, CALC, RESP.
- Arbitration, evaluated combinationally in IDLE, and in RESP when resp_valid&resp_ready:
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[winner]=1 in that cycle only; every other req_ready bit is 0 in every other state or cycle.
- Accept edge (req_valid[w]&req_ready[w]):
  - mult_a <= req_a[w], mult_b <= req_b[w].
  - resp_id is loaded with w at the capture edge below, held internally until then.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - counter <= CALC_CYCLES-1; state <= CALC.
- IDLE with no req_valid: stay in IDLE; mult_a/mult_b hold their last values.
- CALC:
  - mult_a/mult_b held stable.
  - Counter decrements each cycle.
  - On the cycle counter==0: resp_data <= mult_out, resp_id <= w, resp_valid <= 1, state <= RESP.
  - mult_out is sampled only on that cycle.
- Latency: accept in cycle T; resp_valid first high in cycle T+1+CALC_CYCLES. With CALC_CYCLES=1, back-to-back throughput is one result per 2 cycles.
- RESP:
  - resp_valid=1; resp_data and resp_id are stable until the handshake completes.
  - No new accept while resp_ready=0, so stalls apply full backpressure to requesters.
  - On resp_ready=1 with a pending req_valid: accept the winner in the same cycle and go to CALC. resp_valid drops next cycle.
  - On resp_ready=1 with no pending request: go to IDLE; resp_valid <= 0.
- Requester rule: req_valid, req_a and req_b stay stable until accepted. The block does not check this.
- Arithmetic:
  - No rounding or saturation; the full 32-bit product is passed through unchanged.
  - Worst case -128.0 * -128.0 = 0x40000000, which is representable.
- Boundary conditions:
  - A requester deasserting valid before being granted is simply not considered.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A single active requester is granted on every arbitration opportunity.

Test Plan:
- Reset, then req0 sends a=0x0180 (1.5), b=0x0200 (2.0), CALC_CYCLES=1, resp_ready=1:
  - req_ready[0] high in cycle 0.
  - resp_valid high in cycle 2 with resp_data=0x00030000 (3.0), resp_id=0.
- Signed case: req2 sends a=0xFF00 (-1.0), b=0x0280 (2.5) -> resp_data=0xFFFD8000 (-2.5), resp_id=2. Then a=0x8000, b=0x8000 -> 0x40000000.
- All four requesters valid continuously, resp_ready=1:
  - Grant order 0,1,2,3,0,1.
  - resp_id follows the same sequence; one result every 2 cycles.
  - req_ready is never more than one-hot.
- Backpressure: hold resp_ready=0 for 5 cycles while req1 and req3 are valid:
  - resp_data and resp_id stay constant; req_ready=0 throughout.
  - On release, req_ready rises in the same cycle and a new result follows 2 cycles later.
- CALC_CYCLES=3 with gate-level SDF: resp_valid arrives at T+4, and the sampled product matches the reference multiply for 100 random a, b in the range -24..23.
- Assert rst_n=0 for one cycle during CALC:
  - Next cycle resp_valid=0, mult_a=mult_b=0, req_ready=0 until a new request.
  - The aborted operation produces no response.
  - The next grant starts from requester 0.

Source files
------------

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin sequencer sharing one combinational mult_1x1 among NUM_REQ requesters
module mult_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int CALC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [15:0]           mult_a,
  output logic [15:0]           mult_b,
  input  logic [31:0]           mult_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id
);

  localparam logic [ID_W:0]   NR_EXT   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ-1);
  localparam logic [3:0]      CNT_INIT = 4'(CALC_CYCLES-1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   rr_ptr, cur_id;
  logic [ID_W-1:0]   off, win, ptr_next;
  logic [ID_W:0]     win_sum;
  logic [NUM_REQ-1:0] rot;
  logic [3:0]        cnt;
  logic              found, arb_en, accept, capture;

  // Rotate so that bit 0 is the requester rr_ptr points at; the lowest set bit wins.
  assign rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int p = NUM_REQ-1; p >= 0; p--) begin
      if (rot[p]) begin
        found = 1'b1;
        off   = ID_W'(p);
      end
    end
  end

  assign win_sum  = {1'b0, rr_ptr} + {1'b0, off};
  assign win      = (win_sum >= NR_EXT) ? ID_W'(win_sum - NR_EXT) : ID_W'(win_sum);
  assign ptr_next = (win == LAST_IDX) ? '0 : win + 1'b1;

  always_comb begin
    state_next = state;
    arb_en     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: arb_en = 1'b1;
      CALC: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        arb_en = resp_ready;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = arb_en && found && rst_n;
    if (accept) state_next = CALC;
  end

  // Gated by rst_n so a requester never sees a grant that reset is about to discard.
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      cnt        <= '0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      if (accept) begin
        mult_a <= req_a[{win, 4'b0000} +: 16];
        mult_b <= req_b[{win, 4'b0000} +: 16];
        cur_id <= win;
        rr_ptr <= ptr_next;
        cnt    <= CNT_INIT;
      end else if (state == CALC && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        resp_data  <= mult_out;
        resp_id    <= cur_id;
        resp_valid <= 1'b1;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - directed and randomized checks of mult_share_arb against a transaction-level model
module tb_mult_share_arb;

  localparam int NR  = 4;
  localparam int CC0 = 1;
  localparam int CC1 = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*16-1:0]  req_a = '0;
  logic [NR*16-1:0]  req_b = '0;
  logic              resp_ready = 1'b1;
  logic [NR-1:0]     rdy0, rdy1;
  logic [15:0]       ma0, mb0, ma1, mb1;
  logic [31:0]       mo0, mo1, rd0, rd1;
  logic              rv0, rv1;
  logic [1:0]        rid0, rid1;

  int      n_tests = 0;
  int      n_fail  = 0;
  longint  cyc     = 0;
  bit      started = 1'b0;

  bit      m_busy [2];
  int      m_ptr  [2];
  int      m_id   [2];
  logic [31:0] m_prod [2];
  longint  m_due  [2];

  logic [NR-1:0] acc;
  int      exp_order [6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational mult_1x1 stand-ins: low 32 bits of the sign-extended product.
  assign mo0 = {{16{ma0[15]}}, ma0} * {{16{mb0[15]}}, mb0};
  assign mo1 = {{16{ma1[15]}}, ma1} * {{16{mb1[15]}}, mb1};

  mult_share_arb #(.NUM_REQ(NR), .ID_W(2), .CALC_CYCLES(CC0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
    .req_a(req_a), .req_b(req_b), .mult_a(ma0), .mult_b(mb0), .mult_out(mo0),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_data(rd0), .resp_id(rid0)
  );

  mult_share_arb #(.NUM_REQ(NR), .ID_W(2), .CALC_CYCLES(CC1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .mult_a(ma1), .mult_b(mb1), .mult_out(mo1),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_data(rd1), .resp_id(rid1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One outstanding operation per instance; responses are due 1+CALC_CYCLES cycles after the grant.
  task automatic model_step(input int d, input logic [NR-1:0] rdy, input logic rv,
                            input logic [31:0] rd, input logic [1:0] rid);
    bit due_now, allow;
    int w, i;
    logic signed [15:0] sa, sb;
    longint p;
    string s;
    s = (d == 0) ? "cc1" : "cc3";
    due_now = m_busy[d] && (cyc >= m_due[d]);
    check({s, "_resp_valid"}, 32'(rv), 32'(due_now));
    if (due_now) begin
      check({s, "_resp_data"}, rd, m_prod[d]);
      check({s, "_resp_id"}, 32'(rid), 32'(m_id[d]));
    end
    if (!rst_n) begin
      check({s, "_ready_in_reset"}, 32'(rdy), 32'd0);
      m_busy[d] = 1'b0;
      m_ptr[d]  = 0;
      return;
    end
    allow = !m_busy[d] || (due_now && resp_ready);
    w = -1;
    if (allow) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_ptr[d] + k) % NR;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    check({s, "_req_ready"}, 32'(rdy), (w >= 0) ? (32'd1 << w) : 32'd0);
    if (due_now && resp_ready) m_busy[d] = 1'b0;
    if (w >= 0) begin
      sa = req_a[16*w +: 16];
      sb = req_b[16*w +: 16];
      p  = longint'(sa) * longint'(sb);
      m_busy[d] = 1'b1;
      m_id[d]   = w;
      m_prod[d] = p[31:0];
      m_due[d]  = cyc + 1 + ((d == 0) ? CC0 : CC1);
      m_ptr[d]  = (w + 1) % NR;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      model_step(0, rdy0, rv0, rd0, rid0);
      model_step(1, rdy1, rv1, rd1, rid1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]    = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  function automatic logic [15:0] rnd_op();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 16'h8000;
    if (s == 1) return 16'($urandom);
    return 16'($urandom_range(0, 47) - 24);
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic single(input int i, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    int n;
    step();
    set_req(i, a, b);
    resp_ready = 1'b1;
    @(negedge clk);
    check("single_grant", 32'(rdy0[i]), 32'd1);
    step();
    req_valid[i] = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rv0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("single_latency", 32'(n), 32'd2);
    check("single_data", rd0, exp);
    check("single_id", 32'(rid0), 32'(i));
    repeat (6) step();
  endtask

  initial begin
    int ng, lastc, gi;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_ptr[d]  = 0;
      m_id[d]   = 0;
      m_prod[d] = '0;
      m_due[d]  = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
    check("rst_mult_a", 32'(ma0), 32'd0);
    check("rst_mult_b", 32'(mb0), 32'd0);
    check("rst_resp_data", rd0, 32'd0);
    check("rst_resp_id", 32'(rid0), 32'd0);
    check("rst_resp_valid", 32'(rv0), 32'd0);
    check("rst_req_ready", 32'(rdy0), 32'd0);

    single(0, 16'h0180, 16'h0200, 32'h0003_0000);
    single(2, 16'hFF00, 16'h0280, 32'hFFFD_8000);
    single(2, 16'h8000, 16'h8000, 32'h4000_0000);

    // All four requesters continuously valid: strict rotation, one grant every 2 cycles.
    do_reset();
    step();
    for (int i = 0; i < NR; i++) set_req(i, rnd_op(), rnd_op());
    resp_ready = 1'b1;
    ng = 0;
    lastc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      acc = rdy0 & req_valid;
      if (acc != '0 && ng < 6) begin
        gi = oh_idx(acc);
        check("rr_order", 32'(gi), 32'(exp_order[ng]));
        if (ng > 0) check("rr_gap", 32'(c - lastc), 32'd2);
        lastc = c;
        ng++;
      end
      step();
      for (int i = 0; i < NR; i++) if (acc[i]) set_req(i, rnd_op(), rnd_op());
    end
    check("rr_count", 32'(ng), 32'd6);
    req_valid = '0;
    repeat (8) step();

    // Backpressure: response stalled for 5 cycles with req1 and req3 pending.
    set_req(1, rnd_op(), rnd_op());
    set_req(3, rnd_op(), rnd_op());
    resp_ready = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(rdy0), 32'd0);
      check("bp_valid_held", 32'(rv0), 32'd1);
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 32'(rdy0 != '0), 32'd1);
    step();
    @(negedge clk);
    check("bp_gap", 32'(rv0), 32'd0);
    step();
    @(negedge clk);
    check("bp_next_result", 32'(rv0), 32'd1);
    step();
    req_valid = '0;
    repeat (8) step();

    // Reset while the operation is in CALC: no response, pointer back to requester 0.
    set_req(1, 16'h0300, 16'h0100);
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(rv0), 32'd0);
    check("abort_mult_a", 32'(ma0), 32'd0);
    check("abort_mult_b", 32'(mb0), 32'd0);
    check("abort_mult_a_cc3", 32'(ma1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("abort_no_resp", 32'(rv0 | rv1), 32'd0);
      check("abort_ready", 32'(rdy0), 32'd0);
    end
    step();
    set_req(0, rnd_op(), rnd_op());
    set_req(2, rnd_op(), rnd_op());
    @(negedge clk);
    check("abort_grant0", 32'(rdy0), 32'd1);
    check("abort_grant0_cc3", 32'(rdy1), 32'd1);
    step();
    req_valid = '0;
    repeat (8) step();

    acc = '0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && acc[i]) begin
          if ($urandom_range(0, 1) != 0) set_req(i, rnd_op(), rnd_op());
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 9) < 3) set_req(i, rnd_op(), rnd_op());
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = rdy0 & req_valid;
    end
    step();
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
